// File: rtl/i2c_bus_monitor.sv
// Passive I2C decoder: deglitches SCL/SDA, flags START/Sr/STOP, and queues {first, byte, ack} for a valid/ready consumer.
// Never drives the bus; a full queue drops the new byte and sets a sticky overflow flag.
`timescale 1ns/1ps
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       system_clock,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_ack,
  output logic       out_first,
  output logic       start_pulse,
  output logic       stop_pulse,
  output logic       bus_busy,
  output logic       bus_error,
  output logic       overflow
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BITS, ACK_BIT} state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic [1:0]             line_sync, filt_q, prev_q;
  logic [CW-1:0]          fcnt_q [2];

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
    end
  end

  assign line_sync = {sda_sync_q[SYNC_STAGES-1], scl_sync_q[SYNC_STAGES-1]};

  // Index 0 is SCL, index 1 is SDA.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      filt_q <= '1;
      prev_q <= '1;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (line_sync[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == CW'(FILTER_LEN - 1)) begin
          filt_q[i] <= line_sync[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + CW'(1);
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_hold_hi, start_det, stop_det;
  assign scl_f       = filt_q[0];
  assign sda_f       = filt_q[1];
  assign scl_rise    = scl_f & ~prev_q[0];
  assign scl_hold_hi = scl_f & prev_q[0];
  assign start_det   = scl_hold_hi & prev_q[1] & ~sda_f;
  assign stop_det    = scl_hold_hi & ~prev_q[1] & sda_f;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       first_q, first_d;
  logic       push, in_byte;

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      first_q   <= first_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    first_d   = first_q;
    if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else if (start_det) begin
      state_d   = BITS;
      bit_cnt_d = '0;
      first_d   = 1'b1;
    end else if (scl_rise) begin
      case (state_q)
        BITS: begin
          shift_d   = {shift_q[6:0], sda_f};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = ACK_BIT;
        end
        ACK_BIT: begin
          first_d   = 1'b0;
          bit_cnt_d = '0;
          state_d   = BITS;
        end
        default: ;
      endcase
    end
  end

  // A STOP or Sr is always preceded by one SCL pulse that lands as bit 1 of a new
  // byte, so only a count above one means the condition broke into real data.
  always_comb begin
    in_byte     = (state_q == ACK_BIT) || (state_q == BITS && bit_cnt_q > 4'd1);
    start_pulse = start_det;
    stop_pulse  = stop_det;
    bus_error   = (start_det | stop_det) & in_byte;
    bus_busy    = (state_q != IDLE);
    push        = scl_rise & ~start_det & ~stop_det & (state_q == ACK_BIT);
  end

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          full, pop, push_ok, overflow_q;

  assign out_valid = (cnt_q != '0);
  assign full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  assign push_ok   = push & (~full | pop);
  assign {out_first, out_data, out_ack} = mem_q[rd_ptr_q];
  assign overflow  = overflow_q;

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= {first_q, shift_q, sda_f};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push & full & ~pop) overflow_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Scoreboarded directed bench for i2c_bus_monitor: expected bytes are queued as
// they are sent, and a negedge monitor checks every popped entry and counts event pulses.
`timescale 1ns/1ps
module tb_i2c_bus_monitor;
  logic       clk = 1'b0;
  logic       rst, scl_r, sda_r, rdy;
  logic       ov, oa, of, sp, pp, bb, be, ovf;
  logic [7:0] od;

  always #5 clk = ~clk;

  i2c_bus_monitor dut (
    .system_clock(clk), .reset(rst), .scl(scl_r), .sda(sda_r),
    .out_valid(ov), .out_ready(rdy), .out_data(od), .out_ack(oa), .out_first(of),
    .start_pulse(sp), .stop_pulse(pp), .bus_busy(bb), .bus_error(be), .overflow(ovf)
  );

  int n_chk = 0, n_fail = 0;
  int start_cnt = 0, stop_cnt = 0, err_cnt = 0;
  int s0, p0, e0;
  logic [9:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sp) start_cnt++;
      if (pp) stop_cnt++;
      if (be) err_cnt++;
      if (ov && rdy) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pop: got %0h, no entry expected", {of, od, oa});
        end else begin
          chk("fifo_entry", 32'({of, od, oa}), 32'(sb_q.pop_front()));
        end
      end
    end
  end

  task automatic wc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_c();
    sda_r = 1'b0; wc(20);
    scl_r = 1'b0; wc(20);
  endtask

  task automatic bit_c(input logic b);
    sda_r = b;    wc(10);
    scl_r = 1'b1; wc(20);
    scl_r = 1'b0; wc(10);
  endtask

  task automatic byte_c(input logic [7:0] d, input logic a, input logic first, input bit exp_push);
    for (int i = 7; i >= 0; i--) bit_c(d[i]);
    if (exp_push) sb_q.push_back({first, d, a});
    bit_c(a);
  endtask

  task automatic stop_c();
    sda_r = 1'b0; wc(10);
    scl_r = 1'b1; wc(20);
    sda_r = 1'b1; wc(20);
  endtask

  task automatic rstart_c();
    sda_r = 1'b1; wc(10);
    scl_r = 1'b1; wc(20);
    sda_r = 1'b0; wc(20);
    scl_r = 1'b0; wc(20);
  endtask

  task automatic mark();
    s0 = start_cnt; p0 = stop_cnt; e0 = err_cnt;
  endtask

  initial begin
    rst = 1'b1; scl_r = 1'b1; sda_r = 1'b1; rdy = 1'b1;
    #1;
    chk("reset_outputs", 32'({ov, od, oa, of, sp, pp, bb, be, ovf}), 32'd0);
    wc(3);
    rst = 1'b0;
    wc(10);

    // Address + data write, NACK on the last byte
    mark();
    start_c();
    chk("t1_busy_after_start", 32'(bb), 32'd1);
    byte_c(8'hA4, 1'b0, 1'b1, 1'b1);
    chk("t1_busy_mid", 32'(bb), 32'd1);
    byte_c(8'h5A, 1'b1, 1'b0, 1'b1);
    stop_c(); wc(10);
    chk("t1_starts", 32'(start_cnt - s0), 32'd1);
    chk("t1_stops", 32'(stop_cnt - p0), 32'd1);
    chk("t1_errors", 32'(err_cnt - e0), 32'd0);
    chk("t1_busy_after_stop", 32'(bb), 32'd0);
    chk("t1_sb_drained", 32'(sb_q.size()), 32'd0);

    // 2-cycle SDA glitch is filtered; 3-cycle one gets through as START then STOP
    mark();
    sda_r = 1'b0; wc(2); sda_r = 1'b1; wc(20);
    chk("t2_glitch_starts", 32'(start_cnt - s0), 32'd0);
    chk("t2_glitch_busy", 32'(bb), 32'd0);
    chk("t2_glitch_fifo", 32'(ov), 32'd0);
    mark();
    sda_r = 1'b0; wc(3); sda_r = 1'b1; wc(20);
    chk("t2_len3_starts", 32'(start_cnt - s0), 32'd1);
    chk("t2_len3_stops", 32'(stop_cnt - p0), 32'd1);
    chk("t2_len3_errors", 32'(err_cnt - e0), 32'd0);
    chk("t2_len3_busy", 32'(bb), 32'd0);

    // STOP in the middle of a byte
    mark();
    start_c();
    bit_c(1'b1); bit_c(1'b0); bit_c(1'b1); bit_c(1'b1);
    stop_c(); wc(10);
    chk("t3_errors", 32'(err_cnt - e0), 32'd1);
    chk("t3_stops", 32'(stop_cnt - p0), 32'd1);
    chk("t3_busy", 32'(bb), 32'd0);
    chk("t3_fifo_empty", 32'(ov), 32'd0);

    // Repeated START between two address bytes
    mark();
    start_c();
    byte_c(8'hA4, 1'b0, 1'b1, 1'b1);
    rstart_c();
    byte_c(8'hA5, 1'b0, 1'b1, 1'b1);
    stop_c(); wc(10);
    chk("t4_starts", 32'(start_cnt - s0), 32'd2);
    chk("t4_stops", 32'(stop_cnt - p0), 32'd1);
    chk("t4_errors", 32'(err_cnt - e0), 32'd0);
    chk("t4_sb_drained", 32'(sb_q.size()), 32'd0);

    // Five bytes into a four-deep queue with the consumer stalled
    rdy = 1'b0;
    start_c();
    byte_c(8'h11, 1'b0, 1'b1, 1'b1);
    byte_c(8'h22, 1'b0, 1'b0, 1'b1);
    byte_c(8'h33, 1'b0, 1'b0, 1'b1);
    byte_c(8'h44, 1'b0, 1'b0, 1'b1);
    byte_c(8'h55, 1'b0, 1'b0, 1'b0);
    stop_c(); wc(10);
    chk("t5_overflow", 32'(ovf), 32'd1);
    chk("t5_valid_full", 32'(ov), 32'd1);
    chk("t5_sb_pending", 32'(sb_q.size()), 32'd4);
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_drain_valid", 32'(ov), 32'd1);
    end
    @(negedge clk);
    chk("t5_drained_valid", 32'(ov), 32'd0);
    chk("t5_sb_drained", 32'(sb_q.size()), 32'd0);
    chk("t5_overflow_sticky", 32'(ovf), 32'd1);
    wc(2);

    // Reset mid-byte, then a clean transaction
    start_c();
    bit_c(1'b1); bit_c(1'b0);
    sda_r = 1'b1; wc(5); scl_r = 1'b1; wc(8);
    chk("t6_busy_before_rst", 32'(bb), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(bb), 32'd0);
    chk("t6_rst_overflow", 32'(ovf), 32'd0);
    chk("t6_rst_outputs", 32'({ov, od, oa, of, sp, pp, be}), 32'd0);
    scl_r = 1'b1; sda_r = 1'b1;
    wc(3);
    rst = 1'b0;
    wc(10);
    mark();
    start_c();
    byte_c(8'h3C, 1'b0, 1'b1, 1'b1);
    stop_c(); wc(10);
    chk("t6_starts", 32'(start_cnt - s0), 32'd1);
    chk("t6_errors", 32'(err_cnt - e0), 32'd0);
    chk("t6_overflow", 32'(ovf), 32'd0);
    chk("t6_busy", 32'(bb), 32'd0);
    chk("t6_sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
